// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes a+b+cin LSB first, one bit per clock, through one
// full-adder cell and a carry register; sum/cout are published only when a result completes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] sum_next;

  fa_cell u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New result bit enters at the MSB; after the last bit this is the complete sum.
  assign sum_next = {fa_sum, sum_sh_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            carry_q  <= fa_carry;
            sum_sh_q <= sum_next[WIDTH-1:1];
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              sum_q  <= sum_next;
              cout_q <= fa_carry;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH 8, plus sweeps at WIDTH 4 and 16.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;

  logic        start8, abort8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start4, abort4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
  logic        start16, abort16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one WIDTH=8 operation; operands are scrambled after capture to catch recapture.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit hold, input logic [7:0] psum, input logic pcout,
                        output int busy_n, output int done_n, output int lat, output int bad);
    busy_n = 0; done_n = 0; lat = -1; bad = 0;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    a8 = ~av; b8 = ~bv; cin8 = ~cv;
    if (!hold) start8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        if (lat < 0) lat = i;
        start8 = 1'b0;
      end
      if (busy8 && done8) bad++;
      if (lat < 0 && (sum8 !== psum || cout8 !== pcout)) bad++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks += 4;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    if (sum8 !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout8); end
  endtask

  task automatic test_zero();
    int bn, dn, lat, bad;
    do_op8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, bn, dn, lat, bad);
    checks += 6;
    if (lat !== 9) begin failures++; $display("FAIL zero_latency got=%0d exp=9", lat); end
    if (bn !== 8) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=8", bn); end
    if (dn !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", dn); end
    if (bad !== 0) begin failures++; $display("FAIL zero_overlap_partial got=%0d exp=0", bad); end
    if (sum8 !== 8'h00) begin failures++; $display("FAIL zero_sum got=%h exp=00", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL zero_cout got=%b exp=0", cout8); end
  endtask

  task automatic test_wrap();
    int bn, dn, lat, bad;
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, bn, dn, lat, bad);
    checks += 4;
    if (lat !== 9) begin failures++; $display("FAIL wrap1_latency got=%0d exp=9", lat); end
    if (bad !== 0) begin failures++; $display("FAIL wrap1_partial got=%0d exp=0", bad); end
    if (sum8 !== 8'h00) begin failures++; $display("FAIL wrap1_sum got=%h exp=00", sum8); end
    if (cout8 !== 1'b1) begin failures++; $display("FAIL wrap1_cout got=%b exp=1", cout8); end
    do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, bn, dn, lat, bad);
    checks += 4;
    if (dn !== 1) begin failures++; $display("FAIL wrap2_done_pulses got=%0d exp=1", dn); end
    if (bad !== 0) begin failures++; $display("FAIL wrap2_partial got=%0d exp=0", bad); end
    if (sum8 !== 8'hFF) begin failures++; $display("FAIL wrap2_sum got=%h exp=ff", sum8); end
    if (cout8 !== 1'b1) begin failures++; $display("FAIL wrap2_cout got=%b exp=1", cout8); end
  endtask

  task automatic test_hold_start();
    int bn, dn, lat, bad;
    do_op8(8'h5A, 8'h33, 1'b1, 1'b1, 8'hFF, 1'b1, bn, dn, lat, bad);
    checks += 6;
    if (dn !== 1) begin failures++; $display("FAIL hold_done_pulses got=%0d exp=1", dn); end
    if (bn !== 8) begin failures++; $display("FAIL hold_busy_cycles got=%0d exp=8", bn); end
    if (lat !== 9) begin failures++; $display("FAIL hold_latency got=%0d exp=9", lat); end
    if (sum8 !== 8'h8E) begin failures++; $display("FAIL hold_sum got=%h exp=8e", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL hold_cout got=%b exp=0", cout8); end
    if (busy8 !== 1'b0) begin failures++; $display("FAIL hold_idle_after got=%b exp=0", busy8); end
  endtask

  task automatic test_abort();
    int dn;
    int got;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    checks += 1;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL abort_to_idle busy=%b exp=0", busy8); end
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dn++;
      @(negedge clk);
    end
    checks += 3;
    if (dn !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
    if (sum8 !== 8'h8E) begin failures++; $display("FAIL abort_sum_kept got=%h exp=8e", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL abort_cout_kept got=%b exp=0", cout8); end
    // start and abort together in IDLE: start must win
    start8 = 1'b1; abort8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; abort8 = 1'b0;
    checks += 1;
    if (busy8 !== 1'b1) begin failures++; $display("FAIL start_beats_abort busy=%b exp=1", busy8); end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin got = 1; break; end
      @(negedge clk);
    end
    checks += 3;
    if (got !== 1) begin failures++; $display("FAIL sa_done_seen got=%0d exp=1", got); end
    if (sum8 !== 8'h30) begin failures++; $display("FAIL sa_sum got=%h exp=30", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL sa_cout got=%b exp=0", cout8); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int bn, dn, lat, bad;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy8); end
    if (done8 !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done8); end
    if (sum8 !== 8'h00) begin failures++; $display("FAIL rst_mid_sum got=%h exp=00", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL rst_mid_cout got=%b exp=0", cout8); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op8(8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, bn, dn, lat, bad);
    checks += 4;
    if (lat !== 9) begin failures++; $display("FAIL post_rst_latency got=%0d exp=9", lat); end
    if (bad !== 0) begin failures++; $display("FAIL post_rst_partial got=%0d exp=0", bad); end
    if (sum8 !== 8'h03) begin failures++; $display("FAIL post_rst_sum got=%h exp=03", sum8); end
    if (cout8 !== 1'b0) begin failures++; $display("FAIL post_rst_cout got=%b exp=0", cout8); end
  endtask

  task automatic test_sweep();
    logic [3:0]  av4, bv4;
    logic [15:0] av16, bv16;
    logic        cv;
    logic [4:0]  e4;
    logic [16:0] e16;
    int          got;
    for (int n = 0; n < 20; n++) begin
      av4 = 4'($urandom_range(0, 15)); bv4 = 4'($urandom_range(0, 15));
      cv = 1'($urandom_range(0, 1));
      e4 = {1'b0, av4} + {1'b0, bv4} + {4'b0, cv};
      @(negedge clk);
      a4 = av4; b4 = bv4; cin4 = cv; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      got = 0;
      for (int i = 0; i < 12; i++) begin
        if (done4) begin got = 1; break; end
        @(negedge clk);
      end
      checks++;
      if (got !== 1 || {cout4, sum4} !== e4) begin
        failures++;
        $display("FAIL sweep4 a=%h b=%h cin=%b done=%0d got=%h exp=%h",
                 av4, bv4, cv, got, {cout4, sum4}, e4);
      end
    end
    for (int n = 0; n < 20; n++) begin
      av16 = 16'($urandom_range(0, 65535)); bv16 = 16'($urandom_range(0, 65535));
      cv = 1'($urandom_range(0, 1));
      e16 = {1'b0, av16} + {1'b0, bv16} + {16'b0, cv};
      @(negedge clk);
      a16 = av16; b16 = bv16; cin16 = cv; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      got = 0;
      for (int i = 0; i < 24; i++) begin
        if (done16) begin got = 1; break; end
        @(negedge clk);
      end
      checks++;
      if (got !== 1 || {cout16, sum16} !== e16) begin
        failures++;
        $display("FAIL sweep16 a=%h b=%h cin=%b done=%0d got=%h exp=%h",
                 av16, bv16, cv, got, {cout16, sum16}, e16);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    start8 = 0; abort8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; abort4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start16 = 0; abort16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_zero();
    test_wrap();
    test_hold_start();
    test_abort();
    test_reset_midrun();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 Port: abort  input  1  cancel an addition in progress; sampled on rising clk.
REQ-006 Port: a  input  WIDTH  first operand; captured only when start is accepted.
REQ-007 Port: b  input  WIDTH  second operand; captured only when start is accepted.
REQ-008 Port: cin  input  1  carry-in; captured only when start is accepted.
REQ-009 Port: busy  output  1  high while an addition is in progress (state RUN).
REQ-010 Port: done  output  1  one-cycle pulse marking a valid, completed result.
REQ-011 Port: sum  output  WIDTH  result of a+b+cin, modulo 2^WIDTH.
REQ-012 Port: cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL compute sum/cout bit-serially, LSB first, using one 1-bit full-adder cell and one carry register, one bit per clock.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at an edge SHALL capture a, b and cin, clear the bit counter, and move to RUN; start=0 SHALL hold IDLE.
REQ-016 RUN: each edge SHALL add bit i of the captured operands plus the carry register, shift the result bit into the sum shift register at the MSB end, update the carry register, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-018 DONE SHALL last one cycle, assert done=1, and return the FSM to IDLE on the next edge.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high in the cycle after edge WIDTH. For WIDTH=8 this is 9 clocks after start.
REQ-020 sum and cout SHALL update only on entry to DONE, and SHALL hold their values until the next entry to DONE or reset; partial results SHALL never appear on sum.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing, and operands SHALL not be recaptured.
REQ-022 abort=1 in RUN SHALL return the FSM to IDLE on that edge with done=0, and SHALL leave sum/cout at their previous values. abort SHALL be ignored in IDLE and DONE.
REQ-023 If start=1 and abort=1 at the same edge in IDLE, start SHALL win.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never be high together.
REQ-025 Wrap-around: the carry out of bit WIDTH-1 SHALL go only to cout; sum SHALL be modulo 2^WIDTH.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry register and operand registers.
REQ-027 Reset asserted during RUN SHALL discard the operation; after release, the block SHALL accept start on the first edge.

Structure
REQ-028 A shared package serial_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The 1-bit adder SHALL be a separate combinational sub-module fa_cell (inputs a, b, cin; outputs sum, carry), instantiated once.
REQ-030 The counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-031 WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy for 8 cycles, then done pulse in cycle 9; sum=0x00, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 a=0x5A, b=0x33, cin=1 -> sum=0x8E, cout=0; start held high through RUN -> exactly one done pulse, and the next operation starts only from IDLE.
REQ-034 Abort after 3 RUN cycles of a=0x10, b=0x20 -> return to IDLE, no done, sum/cout keep the prior result; start and abort together in IDLE -> operation starts.
REQ-035 rst_n low mid-RUN between clock edges -> outputs 0 immediately; after release, a=0x01, b=0x02, cin=0 -> sum=0x03.
REQ-036 Random sweep at WIDTH=4 and WIDTH=16 -> {cout,sum} equals a+b+cin for every operation.
